// File: rtl/uart_rx_byte_pkg.sv
// Shared types and constants for the uart_rx_byte receiver.
package uart_rx_byte_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return (clk_freq + baud_rate * oversample / 2) / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Line input and received-byte output bundle of the serial receiver.
interface uart_rx_byte_if;
  logic       enable;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  modport master (
    input  enable, rxd,
    output rx_data, rx_data_valid, parity_error, frame_error, busy
  );

  modport slave (
    output enable, rxd,
    input  rx_data, rx_data_valid, parity_error, frame_error, busy
  );
endinterface

// File: rtl/uart_rx_sync_filter.sv
// Two-flop synchronizer on the raw rxd pin plus registered falling-edge detect.
module uart_rx_sync_filter (
  input  logic clk,
  input  logic resetn,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Idle line is high, so all stages come out of reset at 1 to avoid a false edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxd_s = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampling UART byte receiver: majority-voted bits, optional parity, stop check,
// exactly one strobe per completed frame, BREAK hold-off after a framing error.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic            clk,
  input logic            resetn,
  uart_rx_byte_if.master rx_if
);

  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TcW  = $clog2(OVERSAMPLE);
  localparam logic [TcW-1:0] TcLast   = TcW'(OVERSAMPLE - 1);
  localparam logic [TcW-1:0] TcDecide = TcW'(OVERSAMPLE / 2 + 1);

  logic rxd_s, fall;

  uart_rx_sync_filter u_sync (
    .clk   (clk),
    .resetn(resetn),
    .rxd   (rx_if.rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  rx_state_e       state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [TcW-1:0]  tcnt_q, tcnt_d;
  logic [1:0]      samp_q, samp_d;
  logic [2:0]      bit_q, bit_d;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      shift_q, shift_d, data_q, data_d;
  logic            par_err_q, par_err_d, stop_bad_q, stop_bad_d;
  logic            valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic            tick, go_start, decide, bit_end, maj, stop_bad_now;

  assign tick     = (div_q == DivW'(DIV - 1));
  assign go_start = (state_q == StIdle) && rx_if.enable && fall;
  assign div_d    = (go_start || tick) ? '0 : div_q + 1'b1;
  assign decide   = tick && (tcnt_q == TcDecide);
  assign bit_end  = tick && (tcnt_q == TcLast);
  // samp_q holds the two previous ticks, so at TcDecide the vote covers OS/2-1..OS/2+1.
  assign samp_d   = tick ? {samp_q[0], rxd_s} : samp_q;
  assign maj      = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxd_s) | (samp_q[0] & rxd_s);

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bit_d        = bit_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    par_err_d    = par_err_q;
    stop_bad_d   = stop_bad_q;
    valid_d      = 1'b0;
    perr_d       = 1'b0;
    ferr_d       = 1'b0;
    stop_bad_now = stop_bad_q | ~maj;

    if (tick && state_q != StIdle && state_q != StBreak) begin
      tcnt_d = (tcnt_q == TcLast) ? '0 : tcnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (go_start) begin
          state_d    = StStart;
          tcnt_d     = '0;
          bit_d      = '0;
          stop_idx_d = 1'b0;
          par_err_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (decide && maj) state_d = StIdle;
        else if (bit_end)  state_d = StData;
      end
      StData: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY != PAR_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        if (decide) begin
          par_err_d = (PARITY == PAR_ODD) ? ~(^shift_q ^ maj) : (^shift_q ^ maj);
        end
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (decide) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            if (stop_bad_now) begin
              ferr_d  = 1'b1;
              state_d = StBreak;
              tcnt_d  = '0;
            end else if (par_err_q) begin
              perr_d  = 1'b1;
              state_d = StIdle;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
              state_d = StIdle;
            end
          end else begin
            stop_bad_d = stop_bad_now;
          end
        end else if (bit_end) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      StBreak: begin
        // tcnt counts consecutive high ticks; any low restarts the bit-time wait.
        if (tick) begin
          if (!rxd_s)                state_d = StBreak;
          else if (tcnt_q == TcLast) state_d = StIdle;
          if (!rxd_s)                tcnt_d = '0;
          else                       tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!rx_if.enable) begin
      state_d = StIdle;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      div_q      <= '0;
      tcnt_q     <= '0;
      samp_q     <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tcnt_q     <= tcnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_err_q  <= par_err_d;
      stop_bad_q <= stop_bad_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_data_valid = valid_q;
  assign rx_if.parity_error  = perr_q;
  assign rx_if.frame_error   = ferr_q;
  assign rx_if.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: an 8N1 receiver and an 8E1 receiver driven with serial frames,
// each frame's outcome predicted from the data/parity/stop bits that were sent.
module tb_uart_rx_byte;
  import uart_rx_byte_pkg::*;

  localparam int KValid = 0;
  localparam int KPerr  = 1;
  localparam int KFerr  = 2;
  localparam int Os     = 16;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        resetn;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          viol_n = 0, viol_e = 0;
  ev_t         ev_n[$], ev_e[$];
  logic [7:0]  last_n = 8'h00, last_e = 8'h00;
  logic [7:0]  mon_last_n, mon_last_e;
  int unsigned last_ts, last_ec;

  uart_rx_byte_if if_n ();
  uart_rx_byte_if if_e ();

  uart_rx_byte #(
    .CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)
  ) u_dut_n (
    .clk(clk), .resetn(resetn), .rx_if(if_n)
  );

  uart_rx_byte #(
    .CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)
  ) u_dut_e (
    .clk(clk), .resetn(resetn), .rx_if(if_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = 2'(k);
    e.data = d;
    e.cyc  = cyc;
    return e;
  endfunction

  // Record every strobe; flag simultaneous strobes and rx_data moving without a valid.
  always @(negedge clk) begin
    if (resetn) begin
      if (if_n.rx_data_valid) ev_n.push_back(mk(KValid, if_n.rx_data));
      if (if_n.parity_error)  ev_n.push_back(mk(KPerr, if_n.rx_data));
      if (if_n.frame_error)   ev_n.push_back(mk(KFerr, if_n.rx_data));
      if (($countones({if_n.rx_data_valid, if_n.parity_error, if_n.frame_error}) > 1) ||
          (if_n.rx_data !== mon_last_n && !if_n.rx_data_valid)) viol_n++;
    end
    mon_last_n = if_n.rx_data;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (if_e.rx_data_valid) ev_e.push_back(mk(KValid, if_e.rx_data));
      if (if_e.parity_error)  ev_e.push_back(mk(KPerr, if_e.rx_data));
      if (if_e.frame_error)   ev_e.push_back(mk(KFerr, if_e.rx_data));
      if (($countones({if_e.rx_data_valid, if_e.parity_error, if_e.frame_error}) > 1) ||
          (if_e.rx_data !== mon_last_e && !if_e.rx_data_valid)) viol_e++;
    end
    mon_last_e = if_e.rx_data;
  end

  // Outcome of a frame from its contents: stop error beats parity error beats good byte.
  function automatic int exp_kind(input logic [7:0] d, input int par_mode, input logic p,
                                  input logic stop_ok);
    int ones = $countones({d, p});
    if (!stop_ok) return KFerr;
    if (par_mode == 1 && (ones % 2) != 1) return KPerr;
    if (par_mode == 2 && (ones % 2) != 0) return KPerr;
    return KValid;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) if_n.rxd = v;
    else          if_e.rxd = v;
  endtask

  task automatic idle(input int sel, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      set_line(sel, 1'b1);
    end
  endtask

  // One clock per line sample; nclk < 0 sends the whole frame.
  task automatic send_frame(input int sel, input logic [7:0] d, input int par_mode,
                            input logic p, input logic stop_val, input int spike_bit,
                            input int nclk, output int unsigned t_start);
    logic bits[$];
    logic v;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_mode != 0) bits.push_back(p);
    bits.push_back(stop_val);
    t_start = 0;
    for (int n = 0; n < int'(bits.size()) * Os; n++) begin
      if (nclk >= 0 && n >= nclk) break;
      @(posedge clk);
      #1;
      if (n == 0) t_start = cyc;
      v = bits[n / Os];
      if ((n / Os) == spike_bit + 1 && (n % Os) == 9) v = ~v;
      set_line(sel, v);
    end
  endtask

  task automatic check_ev(input int sel, input int kind, input logic [7:0] d, input string tag,
                          output int unsigned ecyc);
    ev_t e;
    int  n;
    n    = (sel == 0) ? ev_n.size() : ev_e.size();
    ecyc = 0;
    chk({tag, "_seen"}, 32'(n > 0), 32'd1);
    if (n > 0) begin
      if (sel == 0) e = ev_n.pop_front();
      else          e = ev_e.pop_front();
      chk({tag, "_kind"}, 32'(e.kind), 32'(kind));
      chk({tag, "_data"}, 32'(e.data), 32'(d));
      ecyc = e.cyc;
    end
  endtask

  task automatic run_frame(input int sel, input logic [7:0] d, input logic p,
                           input logic stop_val, input int spike_bit, input string tag);
    int          k, pm;
    int unsigned ts, ec;
    logic [7:0]  held;
    pm   = (sel == 0) ? 0 : 2;
    k    = exp_kind(d, pm, p, stop_val);
    held = (sel == 0) ? last_n : last_e;
    send_frame(sel, d, pm, p, stop_val, spike_bit, -1, ts);
    check_ev(sel, k, (k == KValid) ? d : held, tag, ec);
    if (k == KValid) begin
      if (sel == 0) last_n = d;
      else          last_e = d;
    end
    last_ts = ts;
    last_ec = ec;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 32'(ev_n.size() + ev_e.size()), 32'd0);
  endtask

  initial begin
    int unsigned ts;
    logic [7:0]  d;
    logic        p;

    resetn      = 1'b0;
    if_n.enable = 1'b1;
    if_e.enable = 1'b1;
    if_n.rxd    = 1'b1;
    if_e.rxd    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(if_n.rx_data), 32'h0);
    chk("rst_strobes", 32'({if_n.rx_data_valid, if_n.parity_error, if_n.frame_error}), 32'h0);
    chk("rst_busy", 32'(if_n.busy), 32'h0);
    chk("rst_busy_e", 32'(if_e.busy), 32'h0);
    resetn = 1'b1;
    idle(0, 5);

    // Back-to-back 8N1 frames; latency counted from the first edge sampling the start bit.
    run_frame(0, 8'hEB, 1'b0, 1'b1, -1, "b2b_first");
    chk("latency", last_ec - last_ts - 1, 32'd156);
    run_frame(0, 8'h90, 1'b0, 1'b1, -1, "b2b_second");
    idle(0, 20);
    chk_quiet("b2b_quiet");

    // Even parity: good byte, wrong parity bit, then corrected resend.
    d = 8'h3A;
    p = ^d;
    run_frame(1, d, p, 1'b1, -1, "par_good");
    run_frame(1, 8'hA5, 1'b1, 1'b1, -1, "par_bad");
    chk("par_bad_held", 32'(if_e.rx_data), 32'h3A);
    run_frame(1, 8'hA5, 1'b0, 1'b1, -1, "par_resend");
    idle(1, 20);

    // Stop bit forced low, line held low 40 bit times, then released.
    run_frame(0, 8'h55, 1'b0, 1'b0, -1, "ferr");
    repeat (40 * Os) @(posedge clk);
    #1;
    chk("break_busy", 32'(if_n.busy), 32'd1);
    chk_quiet("break_quiet");
    set_line(0, 1'b1);
    idle(0, 10);
    chk("break_short_high", 32'(if_n.busy), 32'd1);
    idle(0, 10);
    chk("break_exit", 32'(if_n.busy), 32'd0);
    run_frame(0, 8'h3C, 1'b0, 1'b1, -1, "after_break");
    idle(0, 20);

    // Four-clock glitch on an idle line.
    @(posedge clk);
    #1;
    set_line(0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_busy", 32'(if_n.busy), 32'd1);
    set_line(0, 1'b1);
    idle(0, 10);
    chk("glitch_idle", 32'(if_n.busy), 32'd0);
    chk_quiet("glitch_quiet");

    // One-clock inverted spike at the centre of data bit 3.
    run_frame(0, 8'h0F, 1'b0, 1'b1, 3, "spike");
    idle(0, 20);

    // Enable dropped mid data bit 4, then re-enabled.
    send_frame(0, 8'h77, 0, 1'b0, 1'b1, -1, Os * 5 + 8, ts);
    chk("en_busy_before", 32'(if_n.busy), 32'd1);
    if_n.enable = 1'b0;
    idle(0, 1);
    chk("en_drop_busy", 32'(if_n.busy), 32'd0);
    idle(0, 30);
    chk_quiet("en_quiet");
    chk("en_data_held", 32'(if_n.rx_data), 32'(last_n));
    if_n.enable = 1'b1;
    idle(0, 5);
    run_frame(0, 8'h12, 1'b0, 1'b1, -1, "en_resume");
    idle(0, 5);

    // Random bytes on both receivers; parity bit random on the even-parity one.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      run_frame(0, d, 1'b0, 1'b1, -1, "rand_n");
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      run_frame(1, d, p, 1'b1, -1, "rand_e");
    end
    idle(0, 10);
    chk_quiet("rand_quiet");

    // Reset asserted mid-byte clears every output at once.
    send_frame(0, 8'h77, 0, 1'b0, 1'b1, -1, 60, ts);
    resetn = 1'b0;
    #1;
    chk("midrst_data", 32'(if_n.rx_data), 32'h0);
    chk("midrst_busy", 32'(if_n.busy), 32'h0);
    chk("midrst_strobes", 32'({if_n.rx_data_valid, if_n.parity_error, if_n.frame_error}),
        32'h0);
    chk("midrst_data_e", 32'(if_e.rx_data), 32'h0);
    set_line(0, 1'b1);
    idle(0, 5);
    resetn = 1'b1;
    idle(0, 200);
    chk_quiet("midrst_quiet");
    chk("strobe_rules_n", 32'(viol_n), 32'd0);
    chk("strobe_rules_e", 32'(viol_e), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
